// File: rtl/ksa_if.sv
// s_mem access and start/done handshake bundle shared by the RC4 key-scheduling engine.
// The engine takes the slave side; the top-level mux/controller takes the master side.
interface ksa_if;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic [7:0]  addr;
    logic [7:0]  rddata;
    logic [7:0]  wrdata;
    logic        wren;

    modport slave  (input  en, key, rddata, output rdy, addr, wrdata, wren);
    modport master (output en, key, rddata, input  rdy, addr, wrdata, wren);
endinterface

// File: rtl/ksa.sv
// RC4 key-scheduling engine: one read-read-write-write swap of S[i]/S[j] per 6-cycle
// iteration over the single-port s_mem, i = 0..255.
module ksa (
    input  logic  clk,
    input  logic  rst_n,
    ksa_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, RD_I, LD_I, RD_J, LD_J, WR_I, WR_J} state_t;

    state_t      state, state_nx;
    logic [7:0]  i, j, si, sj;
    logic [23:0] key_q;
    logic [1:0]  imod3;
    logic [7:0]  kb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Outputs decode from state and registers only, so none of them sees en/rddata.
    always_comb begin
        state_nx   = state;
        bus.rdy    = 1'b0;
        bus.wren   = 1'b0;
        bus.addr   = 8'd0;
        bus.wrdata = 8'd0;
        case (state)
            IDLE: begin
                bus.rdy = 1'b1;
                if (bus.en) state_nx = RD_I;
            end
            RD_I: begin
                bus.addr = i;
                state_nx = LD_I;
            end
            LD_I: state_nx = RD_J;
            RD_J: begin
                bus.addr = j;
                state_nx = LD_J;
            end
            LD_J: state_nx = WR_I;
            WR_I: begin
                bus.addr   = i;
                bus.wrdata = sj;
                bus.wren   = 1'b1;
                state_nx   = WR_J;
            end
            WR_J: begin
                bus.addr   = j;
                bus.wrdata = si;
                bus.wren   = 1'b1;
                state_nx   = (i == 8'hFF) ? IDLE : RD_I;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        case (imod3)
            2'd0:    kb = key_q[23:16];
            2'd1:    kb = key_q[15:8];
            default: kb = key_q[7:0];
        endcase
    end

    // imod3 tracks i mod 3 incrementally to avoid a divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i     <= 8'd0;
            j     <= 8'd0;
            si    <= 8'd0;
            sj    <= 8'd0;
            key_q <= 24'd0;
            imod3 <= 2'd0;
        end else begin
            case (state)
                IDLE: if (bus.en) begin
                    key_q <= bus.key;
                    i     <= 8'd0;
                    j     <= 8'd0;
                    imod3 <= 2'd0;
                end
                LD_I: begin
                    si <= bus.rddata;
                    j  <= j + bus.rddata + kb;
                end
                LD_J: sj <= bus.rddata;
                WR_J: if (i != 8'hFF) begin
                    i     <= i + 8'd1;
                    imod3 <= (imod3 == 2'd2) ? 2'd0 : imod3 + 2'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ksa.sv
// Self-checking bench for ksa: behavioural s_mem plus a plain software RC4 KSA reference.
module tb_ksa;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    ksa_if bus();
    ksa dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic       init_req = 1'b0;

    // Synchronous single-port RAM: 1-cycle read latency, write at the rising edge.
    always @(posedge clk) begin
        if (init_req)
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
        else if (bus.wren)
            mem[bus.addr] <= bus.wrdata;
        bus.rddata <= mem[bus.addr];
    end

    int         ref_s [256];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] wa [$];
    logic [7:0] wd [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ref_identity();
        for (int k = 0; k < 256; k++) ref_s[k] = k;
    endtask

    // Textbook RC4 key schedule with a 3-byte key, byte 0 being the most significant.
    task automatic ref_ksa(input logic [23:0] k);
        int jj, kb, t;
        jj = 0;
        for (int ii = 0; ii < 256; ii++) begin
            kb = int'((k >> (8 * (2 - (ii % 3)))) & 24'hFF);
            jj = (jj + ref_s[ii] + kb) % 256;
            t = ref_s[ii]; ref_s[ii] = ref_s[jj]; ref_s[jj] = t;
        end
    endtask

    task automatic load_identity();
        @(negedge clk); init_req = 1'b1;
        @(negedge clk); init_req = 1'b0;
    endtask

    task automatic mem_check(input string tag);
        int bad;
        bad = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== 8'(ref_s[k])) bad++;
        check(tag, bad, 0);
    endtask

    task automatic start(input logic [23:0] k, input bit hold);
        @(negedge clk); bus.key = k; bus.en = 1'b1;
        @(negedge clk); if (!hold) bus.en = 1'b0;
    endtask

    // mode 0 plain, 1 = en/key disturbance at cycle 700, 2 = reset at cycle 900.
    task automatic wait_done(input int mode, input logic [23:0] k, output int busy, output int nwr);
        busy = 0; nwr = 0;
        wa.delete(); wd.delete();
        while (bus.rdy === 1'b0 && busy < 2000) begin
            busy++;
            if (bus.wren === 1'b1) begin
                nwr++; wa.push_back(bus.addr); wd.push_back(bus.wrdata);
            end
            if (mode == 1 && busy == 700) begin bus.en = 1'b1; bus.key = ~k; end
            if (mode == 1 && busy == 703) bus.en = 1'b0;
            if (mode == 2 && busy == 900) begin
                rst_n = 1'b0;
                #1;
                check("midrst_wren", bus.wren, 1'b0);
                check("midrst_rdy", bus.rdy, 1'b1);
                check("midrst_addr", bus.addr, 8'd0);
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int busy, nwr, bad, gap;
        logic [23:0] k;
        logic [7:0] exp_a [6];
        logic [7:0] exp_d [6];
        bus.en = 1'b0; bus.key = 24'd0;

        #2;
        check("rst_rdy", bus.rdy, 1'b1);
        check("rst_wren", bus.wren, 1'b0);
        check("rst_addr", bus.addr, 8'd0);
        check("rst_wrdata", bus.wrdata, 8'd0);
        load_identity();
        @(negedge clk); rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.wren !== 1'b0 || bus.addr !== 8'd0 || bus.rdy !== 1'b1) bad++;
        end
        check("idle_quiet", bad, 0);

        // Known key on identity memory
        exp_a = '{8'd0, 8'd0, 8'd1, 8'd4, 8'd2, 8'd66};
        exp_d = '{8'd0, 8'd0, 8'd4, 8'd1, 8'd66, 8'd2};
        ref_identity(); ref_ksa(24'h00033C);
        start(24'h00033C, 1'b0);
        wait_done(0, 24'h00033C, busy, nwr);
        check("k1_busy", busy, 1536);
        check("k1_nwr", nwr, 512);
        for (int w = 0; w < 6; w++) begin
            if (w < wa.size()) begin
                check($sformatf("k1_waddr%0d", w), wa[w], exp_a[w]);
                check($sformatf("k1_wdata%0d", w), wd[w], exp_d[w]);
            end else check($sformatf("k1_wmissing%0d", w), wa.size(), 6);
        end
        bad = 0;
        if (wa.size() == 512) for (int w = 0; w < 256; w++) if (wa[2*w] !== 8'(w)) bad++;
        check("k1_worder", bad, 0);
        mem_check("k1_mem");

        // All-ones key
        load_identity();
        ref_identity(); ref_ksa(24'hFFFFFF);
        start(24'hFFFFFF, 1'b0);
        wait_done(0, 24'hFFFFFF, busy, nwr);
        check("kff_busy", busy, 1536);
        check("kff_nwr", nwr, 512);
        mem_check("kff_mem");

        // Random keys
        for (int r = 0; r < 2; r++) begin
            k = 24'($urandom());
            load_identity();
            ref_identity(); ref_ksa(k);
            start(k, 1'b0);
            wait_done(0, k, busy, nwr);
            check("rnd_busy", busy, 1536);
            mem_check("rnd_mem");
        end

        // en/key disturbance while busy
        k = 24'($urandom());
        load_identity();
        ref_identity(); ref_ksa(k);
        start(k, 1'b0);
        wait_done(1, k, busy, nwr);
        check("dist_busy", busy, 1536);
        check("dist_nwr", nwr, 512);
        mem_check("dist_mem");

        // Reset mid-run, then recover with a fresh run
        k = 24'($urandom());
        load_identity();
        start(k, 1'b0);
        wait_done(2, k, busy, nwr);
        check("midrst_at", busy, 900);
        load_identity();
        @(negedge clk); rst_n = 1'b1;
        k = 24'($urandom());
        ref_identity(); ref_ksa(k);
        start(k, 1'b0);
        wait_done(0, k, busy, nwr);
        check("postrst_busy", busy, 1536);
        mem_check("postrst_mem");

        // Back-to-back with en held: second run operates on the first's output
        k = 24'($urandom());
        load_identity();
        ref_identity(); ref_ksa(k); ref_ksa(k);
        start(k, 1'b1);
        wait_done(0, k, busy, nwr);
        check("b2b_busy1", busy, 1536);
        gap = 0;
        while (bus.rdy === 1'b1 && gap < 10) begin
            gap++;
            @(negedge clk);
        end
        bus.en = 1'b0;
        check("b2b_gap", gap, 1);
        wait_done(0, k, busy, nwr);
        check("b2b_busy2", busy, 1536);
        check("b2b_nwr2", nwr, 512);
        mem_check("b2b_mem");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
